// File: rtl/calc_sequencer.sv
// Calculator key sequencer: debounces key presses, assembles two signed 3-digit BCD
// operands and an operator, then hands off to the arithmetic unit and tracks its outcome.
module calc_sequencer #(
  parameter int RELEASE_CYC = 20,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_hit,
  input  logic [3:0]  key_code,
  input  logic        key_type,
  input  logic        alu_done,
  input  logic        alu_err,
  output logic [11:0] num1,
  output logic [11:0] num2,
  output logic        sig1,
  output logic        sig2,
  output logic [1:0]  op,
  output logic        alu_start,
  output logic        busy,
  output logic        show_result,
  output logic        err_flag,
  output logic [1:0]  dig_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_ENTER1 = 3'd0, S_ENTER2 = 3'd1, S_START = 3'd2,
    S_WAIT   = 3'd3, S_SHOW   = 3'd4, S_ERROR = 3'd5
  } state_e;

  localparam int              TW       = (ALU_TIMEOUT < 3) ? 2 : $clog2(ALU_TIMEOUT);
  localparam logic [TW-1:0]   TMO_LAST = TW'(ALU_TIMEOUT - 1);
  localparam logic [7:0]      REL_TH   = 8'(RELEASE_CYC);

  state_e        state_q, state_d;
  logic [11:0]   num1_q, num1_d, num2_q, num2_d;
  logic          sig1_q, sig1_d, sig2_q, sig2_d;
  logic [1:0]    op_q, op_d, dig_cnt_q, dig_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rel_cnt_q, rel_cnt_d;
  logic          key_hit_q, armed_q, armed_d;
  logic          alu_start_q, busy_q, show_q, err_q;

  logic key_ev, is_digit, is_fn, is_clr, is_op, is_minus, is_eq, en2;

  assign key_ev   = key_hit & ~key_hit_q & armed_q;
  assign is_digit = key_ev & ~key_type;
  assign is_fn    = key_ev & key_type;
  assign is_clr   = is_fn & (key_code == 4'hF);
  assign is_op    = is_fn & (key_code >= 4'hA) & (key_code <= 4'hD);
  assign is_minus = is_fn & (key_code == 4'hB);
  assign is_eq    = is_fn & (key_code == 4'hE);
  assign en2      = (state_q == S_ENTER2);

  // Re-arm only after key_hit has stayed low for RELEASE_CYC consecutive cycles.
  always_comb begin
    rel_cnt_d = key_hit ? 8'd0 : ((rel_cnt_q == 8'hFF) ? rel_cnt_q : rel_cnt_q + 8'd1);
    armed_d   = armed_q;
    if (key_ev)                             armed_d = 1'b0;
    else if (!key_hit && rel_cnt_d >= REL_TH) armed_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    sig1_d    = sig1_q;
    sig2_d    = sig2_q;
    op_d      = op_q;
    dig_cnt_d = dig_cnt_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_ENTER1, S_ENTER2: begin
        if (is_digit && dig_cnt_q != 2'd3) begin
          if (en2) num2_d = {num2_q[7:0], key_code};
          else     num1_d = {num1_q[7:0], key_code};
          dig_cnt_d = dig_cnt_q + 2'd1;
        end else if (is_minus && dig_cnt_q == 2'd0) begin
          if (en2) sig2_d = ~sig2_q;
          else     sig1_d = ~sig1_q;
        end else if (is_op && dig_cnt_q != 2'd0 && !en2) begin
          op_d      = key_code[1:0] - 2'd2;  // A..D -> 00..11
          dig_cnt_d = 2'd0;
          state_d   = S_ENTER2;
        end else if (is_eq && dig_cnt_q != 2'd0 && en2) begin
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (alu_done)                state_d = alu_err ? S_ERROR : S_SHOW;
        else if (tmo_q == TMO_LAST)  state_d = S_ERROR;
      end
      S_SHOW: begin
        if (is_digit) begin
          num1_d    = {8'h00, key_code};
          num2_d    = '0;
          sig1_d    = 1'b0;
          sig2_d    = 1'b0;
          op_d      = '0;
          dig_cnt_d = 2'd1;
          state_d   = S_ENTER1;
        end
      end
      S_ERROR: ;
      default: state_d = S_ENTER1;
    endcase
    // Clear beats everything, including a coincident alu_done.
    if (is_clr) begin
      num1_d    = '0;
      num2_d    = '0;
      sig1_d    = 1'b0;
      sig2_d    = 1'b0;
      op_d      = '0;
      dig_cnt_d = '0;
      tmo_d     = '0;
      state_d   = S_ENTER1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_ENTER1;
      num1_q      <= '0;
      num2_q      <= '0;
      sig1_q      <= 1'b0;
      sig2_q      <= 1'b0;
      op_q        <= '0;
      dig_cnt_q   <= '0;
      tmo_q       <= '0;
      rel_cnt_q   <= '0;
      key_hit_q   <= 1'b0;
      armed_q     <= 1'b1;
      alu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      show_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      sig1_q      <= sig1_d;
      sig2_q      <= sig2_d;
      op_q        <= op_d;
      dig_cnt_q   <= dig_cnt_d;
      tmo_q       <= tmo_d;
      rel_cnt_q   <= rel_cnt_d;
      key_hit_q   <= key_hit;
      armed_q     <= armed_d;
      alu_start_q <= (state_d == S_START);
      busy_q      <= (state_d == S_START) || (state_d == S_WAIT);
      show_q      <= (state_d == S_SHOW);
      err_q       <= (state_d == S_ERROR);
    end
  end

  assign num1        = num1_q;
  assign num2        = num2_q;
  assign sig1        = sig1_q;
  assign sig2        = sig2_q;
  assign op          = op_q;
  assign dig_cnt     = dig_cnt_q;
  assign state       = state_q;
  assign alu_start   = alu_start_q;
  assign busy        = busy_q;
  assign show_result = show_q;
  assign err_flag    = err_q;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Keypad-to-arithmetic sequencer for the calculator. Converts key events from the row-scan/column-compare stage into a signed three-digit BCD operand 1, an operator, and operand 2. On '=' it issues a start pulse to the arithmetic unit and waits for completion or timeout. It then exposes result/error status to the display multiplexer, and sits between the keypad decoder and the arithmetic/display blocks in the 1 kHz clock domain.

## Interface
Parameters:
- RELEASE_CYC, 20: consecutive cycles with key_hit low required before a new press is accepted (debounce, 20 ms at 1 kHz).
- ALU_TIMEOUT, 255: maximum cycles spent in WAIT before forcing ERROR.

Ports (clk and rst_n first):
- clk  in  1  system clock (divided 1 kHz clock); all logic on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- key_hit  in  1  high while any key is held (level from the scanner).
- key_code  in  4  key value, valid while key_hit=1.
- key_type  in  1  key class:
  - 0: digit, key_code 0–9.
  - 1: function key, with key_code A=+, B=−, C=×, D=÷, E='=', F=clear.
- alu_done  in  1  one-cycle completion pulse from the arithmetic unit.
- alu_err  in  1  error qualifier (e.g. divide by zero), sampled with alu_done.
- num1, num2  out  12  operand BCD digits, [11:8] hundreds, [7:4] tens, [3:0] units.
- sig1, sig2  out  1  operand sign (1 = negative).
- op  out  2  operator code: 00 add, 01 sub, 10 mul, 11 div.
- alu_start  out  1  one-cycle start pulse.
- busy  out  1  high in START and WAIT.
- show_result  out  1  high in SHOW.
- err_flag  out  1  high in ERROR.
- dig_cnt  out  2  digit count (0–3) of the operand currently being entered.
- state  out  3  FSM state encoding, for debug/display.

## Operation
- Press detection:
  - A key event is accepted on a cycle where key_hit=1, key_hit_q=0 (registered key_hit), and the armed flag=1.
  - The event clears armed. armed sets again only after key_hit has been low for RELEASE_CYC consecutive cycles, counted by an 8-bit saturating counter.
  - key_code and key_type are sampled on the event cycle only.
- FSM states: ENTER1(0), ENTER2(1), START(2), WAIT(3), SHOW(4), ERROR(5). Reset state is ENTER1.
- ENTER1:
  - Digit with dig_cnt<3: shift into num1 (num1 = {num1[7:0], code}), dig_cnt+1. A digit at dig_cnt=3 is ignored.
  - '−' with dig_cnt=0: toggles sig1.
  - Any operator with dig_cnt>0: latch op, clear dig_cnt, go to ENTER2.
  - Operators with dig_cnt=0 (other than the '−' case) and '=' are ignored.
- ENTER2: same rules applied to num2/sig2. '=' with dig_cnt>0 goes to START. Further operator keys with dig_cnt>0 are ignored.
- START: assert alu_start for exactly one cycle, clear the timeout counter, go to WAIT unconditionally.
- WAIT:
  - alu_done=1: go to ERROR if alu_err=1, else to SHOW.
  - Timeout counter reaching ALU_TIMEOUT: go to ERROR.
  - All keys except clear are ignored.
- SHOW:
  - Digit key: clear all operand registers and op, load the digit as num1 units (dig_cnt=1), go to ENTER1.
  - Operator and '=' keys are ignored.
- ERROR: only clear exits.
- Clear, accepted in any state:
  - num1, num2, sig1, sig2, op, dig_cnt and the timeout counter are zeroed; go to ENTER1.
  - If clear arrives in the same cycle as alu_done, clear wins.
  - Any later alu_done outside WAIT is ignored.
- num1/num2/sig1/sig2/op are held stable from START until the next clear or the new-entry path out of SHOW.

## Timing
- All outputs are registered. Reset values:
  - num1, num2 = 12'h000; sig1, sig2 = 0; op = 00.
  - alu_start, busy, show_result, err_flag = 0; dig_cnt = 0; state = 0.
  - armed = 1; key_hit_q = 0.
- Key event latency: registers and state update at the first clock edge after the event cycle, i.e. one cycle after key_hit is first sampled high.
- alu_start is high during the cycle after the '=' event is registered (the state=START cycle). busy rises in that same cycle.
- Done handling: alu_done sampled in WAIT → SHOW or ERROR on the next edge, so show_result/err_flag rise one cycle after alu_done.
- Timeout: ERROR is entered ALU_TIMEOUT+1 cycles after START when no alu_done arrives.
- A held key generates exactly one event. Bounce shorter than RELEASE_CYC low cycles generates none.
- rst_n low at any edge, including mid-WAIT, overrides all other activity.

## Test plan
- Keys 1,2,3,4, +, 5, '=' (each held 10 cycles, released 25) → num1=12'h123, dig_cnt saturates at 3, op=00, num2=12'h005, one alu_start pulse; alu_done=1/alu_err=0 → show_result=1 one cycle later.
- '−', 7, ÷, 0, '=' then alu_done with alu_err=1 → sig1=1, num1=12'h007, op=11, err_flag=1; a digit key has no effect; clear → state=0, all operands zero.
- Bounce on key 9 (high 3, low 5, high 10 cycles) with RELEASE_CYC=20 → num1=12'h009 only, dig_cnt=1.
- '=' pressed in ENTER2 with dig_cnt=0 → no alu_start. Valid operand then '=' with alu_done withheld → ERROR exactly 256 cycles after START.
- In SHOW, press 4 → ENTER1, num1=12'h004, num2=0, op=00. Clear in the same cycle as alu_done during WAIT → ENTER1, show_result stays 0.
- rst_n pulled low for 1 cycle mid-WAIT → all outputs at reset values on the next edge; a later alu_done is ignored.
